// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus: one valid/ready handshake per requester, with
// packed per-requester destination register and write data slices.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rc;
  logic [NREQ*DW-1:0] req_data;

  // Requester side: presents writes and observes the grant.
  modport master (
    output req_valid,
    output req_rc,
    output req_data,
    input  req_ready
  );

  // Arbiter side: observes writes and issues the grant.
  modport slave (
    input  req_valid,
    input  req_rc,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NREQ
// writeback requesters. The winning write is registered for one cycle and
// then presented on the regfile write port.
// Optional feature macro: WB_BYPASS_EN adds read-port forwarding of the
// write currently on the regfile write port.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 i_hold,
  output logic                 o_rf_write_enable,
  output logic [AW-1:0]        o_rf_rc,
  output logic [DW-1:0]        o_rf_write_data,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0]        i_ra,
  input  logic [AW-1:0]        i_rb,
  input  logic [DW-1:0]        i_rd_a_in,
  input  logic [DW-1:0]        i_rd_b_in,
  output logic [DW-1:0]        o_rd_a_out,
  output logic [DW-1:0]        o_rd_b_out,
`endif
  output logic [2:0]           o_grant_id
);

  localparam int PW = 3;

  logic [PW-1:0]   r_rr_ptr;
  logic            r_we_p1;
  logic [AW-1:0]   r_rc_p1;
  logic [DW-1:0]   r_data_p1;
  logic [PW-1:0]   r_gid_p1;

  logic [NREQ-1:0] w_ready;
  logic            w_grant;
  logic [PW-1:0]   w_gnt_idx;
  logic [AW-1:0]   w_sel_rc;
  logic [DW-1:0]   w_sel_data;
  logic [PW-1:0]   w_ptr_next;
  int              w_scan;

  // Stage p0: round-robin search starting at r_rr_ptr; first valid requester wins.
  always_comb begin
    w_ready    = '0;
    w_grant    = 1'b0;
    w_gnt_idx  = '0;
    w_sel_rc   = '0;
    w_sel_data = '0;
    w_scan     = 0;
    if (!rst && !i_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        w_scan = (int'(r_rr_ptr) + k) % NREQ;
        if (!w_grant && wb.req_valid[w_scan]) begin
          w_grant           = 1'b1;
          w_gnt_idx         = PW'(w_scan);
          w_ready[w_scan]   = 1'b1;
          w_sel_rc          = wb.req_rc[w_scan*AW +: AW];
          w_sel_data        = wb.req_data[w_scan*DW +: DW];
        end
      end
    end
  end

  assign wb.req_ready = w_ready;

  // Pointer moves just past the winner so the winner becomes lowest priority.
  always_comb begin
    w_ptr_next = r_rr_ptr;
    if (w_grant) begin
      w_ptr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  // Stage p1: registered winning write; index/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_p1   <= 1'b0;
      r_rc_p1   <= '0;
      r_data_p1 <= '0;
      r_gid_p1  <= '0;
    end else if (w_grant) begin
      r_we_p1   <= 1'b1;
      r_rc_p1   <= w_sel_rc;
      r_data_p1 <= w_sel_data;
      r_gid_p1  <= w_gnt_idx;
    end else begin
      r_we_p1   <= 1'b0;
    end
  end

  assign o_rf_write_enable = r_we_p1;
  assign o_rf_rc           = r_rc_p1;
  assign o_rf_write_data   = r_data_p1;
  assign o_grant_id        = r_gid_p1;

`ifdef WB_BYPASS_EN
  // Forward the write the regfile commits at the next edge onto the read ports.
  always_comb begin
    o_rd_a_out = (r_we_p1 && (r_rc_p1 == i_ra)) ? r_data_p1 : i_rd_a_in;
    o_rd_b_out = (r_we_p1 && (r_rc_p1 == i_rb)) ? r_data_p1 : i_rd_b_in;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic          we;
  logic [AW-1:0] rc;
  logic [DW-1:0] wd;
  logic [2:0]    gid;
`ifdef WB_BYPASS_EN
  logic [AW-1:0] ra, rb;
  logic [DW-1:0] rd_a_in, rd_b_in, rd_a_out, rd_b_out;
`endif

  regfile_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) wb ();

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .wb                (wb.slave),
    .i_hold            (hold),
    .o_rf_write_enable (we),
    .o_rf_rc           (rc),
    .o_rf_write_data   (wd),
`ifdef WB_BYPASS_EN
    .i_ra              (ra),
    .i_rb              (rb),
    .i_rd_a_in         (rd_a_in),
    .i_rd_b_in         (rd_b_in),
    .o_rd_a_out        (rd_a_out),
    .o_rd_b_out        (rd_b_out),
`endif
    .o_grant_id        (gid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: rotating priority pointer, one registered write, regfile image.
  int m_ptr = 0;
  bit m_ok  = 1'b0;
  bit m_we;
  int m_rc, m_data, m_gid;
  int mem [8];

  always @(negedge clk) begin
    int order [$];
    int g;
    logic [NREQ-1:0] er;
    order.delete();
    for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
    g  = -1;
    er = '0;
    if (rst === 1'b0 && hold === 1'b0) begin
      foreach (order[j]) if (g < 0 && wb.req_valid[order[j]] === 1'b1) g = order[j];
    end
    if (g >= 0) er[g] = 1'b1;
    chk("model_ready", 32'(wb.req_ready), 32'(er));
    if (m_ok) begin
      chk("model_we",   32'(we),  32'(m_we));
      chk("model_rc",   32'(rc),  32'(m_rc));
      chk("model_data", 32'(wd),  32'(m_data));
      chk("model_gid",  32'(gid), 32'(m_gid));
      if (m_we) mem[m_rc] = m_data;
    end
    if (rst === 1'b1) begin
      m_we = 0; m_rc = 0; m_data = 0; m_gid = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_we   = 1;
      m_rc   = int'(wb.req_rc[g*AW +: AW]);
      m_data = int'(wb.req_data[g*DW +: DW]);
      m_gid  = g;
      m_ptr  = (g + 1) % NREQ;
    end else begin
      m_we = 0;
    end
    m_ok = 1'b1;
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_g [6];
    exp_g = '{0, 1, 2, 0, 1, 2};
    rst  = 1'b1;
    hold = 1'b0;
    wb.req_valid = '1;
    wb.req_rc    = '0;
    wb.req_data  = '0;
`ifdef WB_BYPASS_EN
    ra = '0; rb = '0; rd_a_in = '0; rd_b_in = '0;
`endif

    // Reset with all requesters valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(wb.req_ready), 32'h0);
    chk("rst_we",    32'(we),  32'h0);
    chk("rst_rc",    32'(rc),  32'h0);
    chk("rst_data",  32'(wd),  32'h0);
    chk("rst_gid",   32'(gid), 32'h0);

    // Single write from requester 1.
    edge1();
    rst = 1'b0;
    wb.req_valid = 3'b010;
    wb.req_rc[1*AW +: AW]   = 3'd5;
    wb.req_data[1*DW +: DW] = 16'hBEEF;
    @(negedge clk);
    chk("single_ready", 32'(wb.req_ready), 32'h2);
    edge1();
    wb.req_valid = '0;
    @(negedge clk);
    chk("single_we",   32'(we),  32'h1);
    chk("single_rc",   32'(rc),  32'h5);
    chk("single_data", 32'(wd),  32'hBEEF);
    chk("single_gid",  32'(gid), 32'h1);
    @(negedge clk);
    chk("single_we_off", 32'(we), 32'h0);

    // Round robin with all three continuously valid, starting from a fresh pointer.
    edge1();
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      wb.req_rc[i*AW +: AW]   = AW'(i + 1);
      wb.req_data[i*DW +: DW] = DW'(16'hA0 + i);
    end
    wb.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      edge1();
      if (c == 5) wb.req_valid = '0;
      @(negedge clk);
      chk("rr_we",  32'(we),  32'h1);
      chk("rr_gid", 32'(gid), 32'(exp_g[c]));
    end
    @(negedge clk);
    chk("rr_we_off", 32'(we), 32'h0);

    // Move the pointer to 2 with one grant to requester 1, then WAW on r3.
    edge1();
    wb.req_valid = 3'b010;
    edge1();
    wb.req_valid = '0;
    wb.req_rc[0*AW +: AW]   = 3'd3;
    wb.req_data[0*DW +: DW] = 16'h0001;
    wb.req_rc[2*AW +: AW]   = 3'd3;
    wb.req_data[2*DW +: DW] = 16'h0002;
    wb.req_valid = 3'b101;
    @(negedge clk);
    chk("waw_ready_first", 32'(wb.req_ready), 32'h4);
    edge1();
    wb.req_valid = 3'b001;
    @(negedge clk);
    chk("waw_data_first", 32'(wd),  32'h2);
    chk("waw_gid_first",  32'(gid), 32'h2);
    chk("waw_ready_next", 32'(wb.req_ready), 32'h1);
    edge1();
    wb.req_valid = '0;
    @(negedge clk);
    chk("waw_data_second", 32'(wd),  32'h1);
    chk("waw_gid_second",  32'(gid), 32'h0);
    chk("waw_rc",          32'(rc),  32'h3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("waw_r3_readback", 32'(mem[3]), 32'h1);

    // Hold blocks grants; rc=0 passes through; reset drops a registered write.
    edge1();
    hold = 1'b1;
    wb.req_rc[0*AW +: AW]   = 3'd0;
    wb.req_data[0*DW +: DW] = 16'h00C3;
    wb.req_valid = 3'b001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_ready", 32'(wb.req_ready), 32'h0);
      chk("hold_we",    32'(we), 32'h0);
      if (c < 2) edge1();
    end
    edge1();
    hold = 1'b0;
    @(negedge clk);
    chk("unhold_ready", 32'(wb.req_ready), 32'h1);
    edge1();
    wb.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("r0_we",   32'(we),  32'h1);
    chk("r0_rc",   32'(rc),  32'h0);
    chk("r0_data", 32'(wd),  32'hC3);
    edge1();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_we", 32'(we), 32'h0);

`ifdef WB_BYPASS_EN
    // Forwarding: write to r4 on the port, ra hits, rb misses.
    edge1();
    wb.req_rc[0*AW +: AW]   = 3'd4;
    wb.req_data[0*DW +: DW] = 16'h1234;
    wb.req_valid = 3'b001;
    ra = 3'd4; rb = 3'd2; rd_a_in = 16'h5555; rd_b_in = 16'h7777;
    edge1();
    wb.req_valid = '0;
    @(negedge clk);
    chk("byp_a_hit",  32'(rd_a_out), 32'h1234);
    chk("byp_b_miss", 32'(rd_b_out), 32'h7777);
    @(negedge clk);
    chk("byp_a_idle", 32'(rd_a_out), 32'h5555);
`endif

    edge1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
